// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: request/grant and muxed transfer-control signals shared by the arbiter and its masters
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MIDX_W = 2
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MIDX_W-1:0] HMASTER;
  logic HMASTLOCK;
  logic [NUM_MASTERS-1:0] sync_grant;
  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input HGRANT, HMASTER, HMASTLOCK, sync_grant
  );
  modport slave (
    input HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTLOCK, sync_grant
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB-Lite arbiter that never splits fixed-length bursts
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MIDX_W = 2
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_bus_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1;
  localparam logic [MIDX_W-1:0] DEF = MIDX_W'(DEFAULT_MASTER);
  logic [MIDX_W-1:0] gnt, gnt_nxt, rr, rr_nxt, hm;
  logic [4:0] cnt, cnt_nxt, fixed_len;
  logic hml, arb_ok, owner_req, owner_lock;
  // HBURST[2:1] selects 4/8/16 beats; SINGLE and INCR have no fixed tail to protect
  always_comb fixed_len = bus.HBURST[2:1] == 2'd1 ? 5'd3 :
                          bus.HBURST[2:1] == 2'd2 ? 5'd7 :
                          bus.HBURST[2:1] == 2'd3 ? 5'd15 : 5'd0;
  always_comb cnt_nxt = !bus.HREADY ? cnt :
                        bus.HTRANS == NONSEQ ? fixed_len :
                        bus.HTRANS == SEQ && cnt != 5'd0 ? cnt - 5'd1 :
                        bus.HTRANS == IDLE ? 5'd0 : cnt;
  always_comb owner_req = bus.HBUSREQ[gnt];
  always_comb owner_lock = bus.HLOCK[gnt];
  always_comb arb_ok = bus.HREADY && (
    ((bus.HTRANS == IDLE || bus.HTRANS == BUSY) && cnt == 5'd0) ||
    (bus.HTRANS == NONSEQ && bus.HBURST == SINGLE) ||
    (bus.HTRANS == SEQ && cnt == 5'd1) ||
    (bus.HTRANS != BUSY && bus.HBURST == INCR));
  // descending scan so the nearest requester after rr wins; owner itself comes last
  always_comb begin
    gnt_nxt = gnt;
    rr_nxt = rr;
    if (arb_ok && !(owner_req && (owner_lock || bus.HBURST == INCR))) begin
      gnt_nxt = DEF;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        if (bus.HBUSREQ[MIDX_W'((int'(rr) + k) % NUM_MASTERS)]) begin
          gnt_nxt = MIDX_W'((int'(rr) + k) % NUM_MASTERS);
          rr_nxt = MIDX_W'((int'(rr) + k) % NUM_MASTERS);
        end
      end
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt <= DEF;
      rr <= DEF;
      cnt <= 5'd0;
      hm <= DEF;
      hml <= 1'b0;
    end else begin
      gnt <= gnt_nxt;
      rr <= rr_nxt;
      cnt <= cnt_nxt;
      if (bus.HREADY) begin
        hm <= gnt;
        hml <= owner_lock;
      end
    end
  end
  assign bus.HGRANT = NUM_MASTERS'(1) << gnt;
  assign bus.sync_grant = NUM_MASTERS'(1) << hm;
  assign bus.HMASTER = hm;
  assign bus.HMASTLOCK = hml;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed test-plan scenarios plus random traffic, scored against a rule-level model
module tb_ahb_bus_arbiter;
  localparam int N = 4;
  localparam int DEF = 0;
  localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;
  ahb_bus_arbiter_if #(.NUM_MASTERS(N), .MIDX_W(2)) bus();
  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .MIDX_W(2)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus)
  );
  typedef struct packed {
    logic [3:0] g;
    logic [1:0] m;
    logic l;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int m_own, m_rr, m_left, m_addr;
  bit m_lk;
  int len_tab [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  function automatic int rr_pick(input logic [3:0] req, input int from);
    for (int k = 1; k <= N; k++)
      if (bit_of(req, (from + k) % N)) return (from + k) % N;
    return -1;
  endfunction

  // model: owner/address-owner as integers, burst tail as a remaining-beat count
  task automatic model(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy);
    bit ok;
    int w;
    if (!HRESETn) begin
      m_own = DEF; m_rr = DEF; m_left = 0; m_addr = DEF; m_lk = 0;
    end else if (rdy) begin
      ok = ((tr == 0 || tr == 1) && m_left == 0) || (tr == 2 && bu == 0) ||
           (tr == 3 && m_left == 1) || (tr != 1 && bu == 1);
      m_addr = m_own;
      m_lk = bit_of(lock, m_own);
      if (ok && !(bit_of(req, m_own) && (bit_of(lock, m_own) || bu == 1))) begin
        w = rr_pick(req, m_rr);
        if (w >= 0) begin m_own = w; m_rr = w; end
        else m_own = DEF;
      end
      m_left = tr == 2 ? len_tab[bu] - 1 : tr == 3 ? (m_left > 0 ? m_left - 1 : 0) :
               tr == 0 ? 0 : m_left;
    end
  endtask

  task automatic step(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rdy, input logic rst_n = 1'b1);
    exp_t x;
    @(negedge HCLK);
    HRESETn = rst_n;
    bus.HBUSREQ = req;
    bus.HLOCK = lock;
    bus.HTRANS = tr;
    bus.HBURST = bu;
    bus.HREADY = rdy;
    model(req, lock, tr, bu, rdy);
    x.g = 4'(1 << m_own);
    x.m = 2'(m_addr);
    x.l = m_lk;
    q.push_back(x);
    if (!rst_n) begin
      #1;
      cmp("async_rst_grant", bus.HGRANT, 4'b0001);
      cmp("async_rst_master", bus.HMASTER, 0);
      cmp("async_rst_lock", bus.HMASTLOCK, 0);
    end
  endtask

  task automatic after(input string nm, input logic [3:0] g, input logic [1:0] m, input logic l);
    logic [3:0] sg;
    @(posedge HCLK);
    #2;
    sg = 4'b0001 << m;
    cmp({nm, "_grant"}, bus.HGRANT, g);
    cmp({nm, "_master"}, bus.HMASTER, m);
    cmp({nm, "_lock"}, bus.HMASTLOCK, l);
    cmp({nm, "_sync"}, bus.sync_grant, sg);
  endtask

  always begin
    @(posedge HCLK);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("sb_grant", bus.HGRANT, e.g);
      cmp("sb_master", bus.HMASTER, e.m);
      cmp("sb_lock", bus.HMASTLOCK, e.l);
      cmp("sb_sync", bus.sync_grant, 4'b0001 << e.m);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.HBUSREQ = 0; bus.HLOCK = 0; bus.HTRANS = IDLE; bus.HBURST = SINGLE; bus.HREADY = 1;
    step(0, 0, IDLE, SINGLE, 1, 0);
    step(0, 0, IDLE, SINGLE, 1, 0);
    after("reset", 4'b0001, 0, 0);
    repeat (10) step(0, 0, IDLE, SINGLE, 1);
    after("idle", 4'b0001, 0, 0);
    step(4'b0100, 0, IDLE, SINGLE, 1);
    after("m2_grant", 4'b0100, 0, 0);
    step(4'b0100, 0, IDLE, SINGLE, 1);
    after("m2_own", 4'b0100, 2, 0);
    repeat (2) step(4'b0010, 0, IDLE, SINGLE, 1);
    step(4'b0110, 0, NONSEQ, INCR4, 1);
    step(4'b0110, 0, SEQ, INCR4, 1);
    step(4'b0110, 0, SEQ, INCR4, 1);
    after("incr4_hold", 4'b0010, 1, 0);
    step(4'b0110, 0, SEQ, INCR4, 1);
    after("incr4_move", 4'b0100, 1, 0);
    step(4'b0100, 0, IDLE, SINGLE, 1);
    after("incr4_own", 4'b0100, 2, 0);
    repeat (2) step(4'b0010, 0, IDLE, SINGLE, 1);
    step(4'b0110, 0, NONSEQ, INCR4, 1);
    step(4'b0110, 0, SEQ, INCR4, 1);
    step(4'b0110, 0, SEQ, INCR4, 0);
    step(4'b0110, 0, SEQ, INCR4, 0);
    after("wait_hold", 4'b0010, 1, 0);
    step(4'b0110, 0, SEQ, INCR4, 1);
    after("wait_last", 4'b0010, 1, 0);
    step(4'b0110, 0, SEQ, INCR4, 1);
    after("wait_move", 4'b0100, 1, 0);
    step(4'b1000, 0, IDLE, SINGLE, 1);
    step(4'b1111, 4'b1000, NONSEQ, SINGLE, 1);
    step(4'b1111, 4'b1000, NONSEQ, SINGLE, 1);
    after("lock_hold", 4'b1000, 3, 1);
    step(4'b0111, 0, IDLE, SINGLE, 1);
    after("lock_release", 4'b0001, 3, 0);
    step(4'b0010, 0, IDLE, SINGLE, 1);
    step(4'b0011, 0, IDLE, INCR, 1);
    step(4'b0011, 0, NONSEQ, INCR, 1);
    repeat (19) step(4'b0011, 0, SEQ, INCR, 1);
    after("incr_hold", 4'b0010, 1, 0);
    step(4'b0001, 0, SEQ, INCR, 1);
    after("incr_drop", 4'b0001, 1, 0);
    step(4'b0000, 0, IDLE, SINGLE, 1);
    step(4'b0000, 0, IDLE, SINGLE, 1);
    after("default", 4'b0001, 0, 0);
    repeat (2) step(4'b0100, 0, IDLE, SINGLE, 1);
    step(4'b0100, 0, NONSEQ, INCR8, 1);
    step(4'b0100, 0, SEQ, INCR8, 1);
    step(4'b0100, 0, SEQ, INCR8, 1, 0);
    step(4'b0100, 0, SEQ, INCR8, 1, 0);
    step(4'b0100, 0, IDLE, SINGLE, 1);
    after("post_reset", 4'b0100, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      r = 4'($urandom);
      step(r, $urandom_range(0, 3) == 0 ? 4'($urandom) & r : 4'b0000,
           2'($urandom), 3'($urandom), $urandom_range(0, 4) != 0,
           $urandom_range(0, 499) != 0);
    end
    step(0, 0, IDLE, SINGLE, 1);
    @(posedge HCLK);
    #3;
    cmp("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
AHB bus arbiter that shares one AHB-Lite address/data path between up to NUM_MASTERS bus masters (DMAC channel master, CPU, test master).
- Samples per-master HBUSREQ/HLOCK and the muxed HTRANS/HBURST/HREADY.
- Drives one-hot HGRANT, HMASTER (address-phase owner select for the bus mux) and HMASTLOCK.
- Also drives per-master sync_grant, which tells a master it owns the current address phase (the DMAC master FSM waits on it).
- Fixed-length bursts are never split; arbitration is round-robin.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..4)
DEFAULT_MASTER, 0, master granted when nobody requests; also the reset owner
MIDX_W, 2, width of HMASTER (ceil log2 NUM_MASTERS, minimum 1)

Ports:
HCLK  in  1  bus clock, all state on rising edge
HRESETn  in  1  asynchronous active-low reset
HBUSREQ  in  NUM_MASTERS  bus request, bit i from master i
HLOCK  in  NUM_MASTERS  locked-transfer request, bit i from master i
HTRANS  in  2  muxed transfer type of current address owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
HBURST  in  3  muxed burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
HREADY  in  1  muxed slave ready
HGRANT  out  NUM_MASTERS  one-hot grant
HMASTER  out  MIDX_W  index of address-phase owner
HMASTLOCK  out  1  current address phase is locked
sync_grant  out  NUM_MASTERS  sync_grant[i] = (HMASTER==i); one-hot

Behaviour:
Reset (async, HRESETn=0):
- HGRANT = one-hot DEFAULT_MASTER; HMASTER = DEFAULT_MASTER; HMASTLOCK = 0; beat_cnt = 0; rr_ptr = DEFAULT_MASTER.
- Reset mid-burst discards all state. No partial burst resumes.

Burst tracking, 5-bit beat_cnt = remaining SEQ beats of owner's fixed burst:
- HREADY=1 and HTRANS=NONSEQ: load len-1. Len is 4/8/16 for WRAP/INCR 4/8/16, 0 for SINGLE/INCR.
- HREADY=1 and HTRANS=SEQ and beat_cnt!=0: decrement.
- HTRANS=IDLE with HREADY=1: clear to 0 (early termination).
- BUSY and HREADY=0: hold.

Arbitration point (arb_ok), true only when HREADY=1 and any of:
- HTRANS=IDLE or BUSY, beat_cnt=0;
- HTRANS=NONSEQ with HBURST=SINGLE;
- HTRANS=SEQ with beat_cnt=1 (last beat of fixed burst);
- HTRANS in {IDLE, NONSEQ, SEQ} with HBURST=INCR.

Hold rules, checked at arb_ok in priority order:
1. Granted master has HLOCK=1 and HBUSREQ=1: keep grant.
2. HBURST=INCR and granted master HBUSREQ=1: keep grant (undefined-length burst ends only when request drops).
3. Otherwise round-robin: search rr_ptr+1, rr_ptr+2, ... modulo NUM_MASTERS, including the current owner last. First requester wins; rr_ptr <= winner.
4. No requests: grant DEFAULT_MASTER; rr_ptr unchanged.

Timing:
- HGRANT updates on the clock edge after arb_ok (1-cycle latency).
- HGRANT holds when arb_ok=0; a wait state (HREADY=0) never moves grant.
- HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[granted] only on edges with HREADY=1 (AHB handover). Ownership therefore changes 1 cycle after HGRANT, or later if HREADY is low.
- Simultaneous request-drop by owner and new request from another at arb_ok: grant moves in the same cycle.

Invariants:
- HGRANT and sync_grant always exactly one-hot.
- HMASTER < NUM_MASTERS.
- An HBUSREQ bit for an index >= NUM_MASTERS is ignored.

Test Plan:
- Reset with HBUSREQ=0000 -> HGRANT=0001, HMASTER=0, HMASTLOCK=0, sync_grant=0001. Holds through 10 idle cycles.
- Master 2 requests alone, HTRANS=IDLE, HREADY=1 -> HGRANT=0100 next edge, HMASTER=2 one edge later, sync_grant=0100.
- Masters 1 and 2 both request, owner 1 issues INCR4 (NONSEQ + 3 SEQ), no wait states -> HGRANT stays 0010 until the 3rd SEQ. Moves to 0100 on the edge after the 3rd SEQ; HMASTER=2 one edge later.
- Same INCR4 with HREADY=0 for 2 cycles on beat 2 -> HGRANT and HMASTER unchanged during waits; beat_cnt held; handover delayed exactly 2 cycles.
- Master 3 HLOCK=1, HBUSREQ=1, other requests active across two SINGLE transfers -> grant stays 1000, HMASTLOCK=1. After HLOCK and HBUSREQ drop, next requester in round-robin order is granted and HMASTLOCK returns to 0.
- Master 1 runs INCR with HBUSREQ high for 20 beats while master 0 requests -> grant held all 20 beats. Master 1 drops HBUSREQ -> HGRANT=0001 next edge. All requests low afterwards -> DEFAULT_MASTER granted. Assert HRESETn low mid-burst -> outputs reset values immediately.
